mem_sram_ctrl: RTL and testbench



---
 rtl/mem_sram_pkg.sv | 14 +
 rtl/sram_read_cache.sv | 32 +++
 rtl/mem_sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states and default geometry.
package mem_sram_pkg;

    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned DEF_SRAM_AW   = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sram_read_cache.sv
// One-entry read cache (valid + word tag) used by mem_sram_ctrl when MEM_READ_CACHE_EN is defined.
// The cached data itself lives in the controller's Mem_read_value register.
module sram_read_cache #(
    parameter int unsigned TAG_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookupTag_i,
    input  logic [TAG_W-1:0] fillTag_i,
    input  logic             fill_i,
    output logic             hit_o,
    output logic             fillMatch_o
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else if (fill_i) begin
            valid_q <= 1'b1;
            tag_q   <= fillTag_i;
        end
    end

    // fillMatch_o compares against the latched word of the access now completing.
    assign hit_o       = valid_q && (tag_q == lookupTag_i);
    assign fillMatch_o = valid_q && (tag_q == fillTag_i);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller: each 32-bit access becomes two 16-bit SRAM half-word cycles.
// Optional one-entry read cache is enabled by defining MEM_READ_CACHE_EN.
module mem_sram_ctrl
    import mem_sram_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_result,
    input  logic [31:0]        ST_val,
    output logic [31:0]        Mem_read_value,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned WAW         = SRAM_AW - 1;
    localparam logic [3:0]  WAIT_RELOAD = 4'(WAIT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WAW-1:0]   wa_q, wa_d;
    logic [31:0]      stVal_q, stVal_d;
    logic             isWrite_q, isWrite_d;
    logic             half_q, half_d;
    logic [15:0]      loTmp_q, loTmp_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             req;
    logic             lastCycle;
    logic             active;
    logic             hit;
    logic             wrHit;
    logic [31:0]      offset;
    logic [WAW-1:0]   waIn;
    logic             unusedOffsetBits;

    assign req              = MEM_R_EN | MEM_W_EN;
    assign offset           = ALU_result - 32'(BASE_ADDR);
    assign waIn             = offset[WAW+1:2];
    assign unusedOffsetBits = ^{offset[31:WAW+2], offset[1:0]};
    assign lastCycle        = (cnt_q == 4'd0);

`ifdef MEM_READ_CACHE_EN
    logic lookHit;
    logic fillMatch;

    sram_read_cache #(
        .TAG_W(WAW)
    ) uCache (
        .clk         (clk),
        .rst         (rst),
        .lookupTag_i (waIn),
        .fillTag_i   (wa_q),
        .fill_i      ((state_q == HI) && lastCycle && !isWrite_q),
        .hit_o       (lookHit),
        .fillMatch_o (fillMatch)
    );

    assign hit   = MEM_R_EN && !MEM_W_EN && (state_q == IDLE) && lookHit;
    assign wrHit = (state_q == HI) && lastCycle && isWrite_q && fillMatch;
`else
    assign hit   = 1'b0;
    assign wrHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wa_q      <= '0;
            stVal_q   <= 32'd0;
            isWrite_q <= 1'b0;
            half_q    <= 1'b0;
            loTmp_q   <= 16'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wa_q      <= wa_d;
            stVal_q   <= stVal_d;
            isWrite_q <= isWrite_d;
            half_q    <= half_d;
            loTmp_q   <= loTmp_d;
            rdata_q   <= rdata_d;
        end
    end

    // The high half is taken straight from the bus on the edge that enters DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wa_d      = wa_q;
        stVal_d   = stVal_q;
        isWrite_d = isWrite_q;
        half_d    = half_q;
        loTmp_d   = loTmp_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d   = LO;
                    cnt_d     = WAIT_RELOAD;
                    wa_d      = waIn;
                    stVal_d   = ST_val;
                    isWrite_d = MEM_W_EN;
                    half_d    = 1'b0;
                end
            end
            LO: begin
                if (lastCycle) begin
                    state_d = HI;
                    cnt_d   = WAIT_RELOAD;
                    half_d  = 1'b1;
                    if (!isWrite_q) loTmp_d = sram_dq_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HI: begin
                if (lastCycle) begin
                    state_d = DONE;
                    if (!isWrite_q) rdata_d = {sram_dq_in, loTmp_q};
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wrHit) rdata_d = stVal_q;
    end

    assign active         = (state_q == LO) || (state_q == HI);
    assign sram_addr      = {wa_q, half_q};
    assign sram_dq_out    = half_q ? stVal_q[31:16] : stVal_q[15:0];
    assign sram_dq_oe     = active && isWrite_q;
    assign sram_we_n      = !(active && isWrite_q);
    assign ready          = !req || (state_q == DONE) || hit;
    assign Mem_read_value = rdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: WAIT_CYCLES=1 and WAIT_CYCLES=3 instances, each with an SRAM model.
// Defining MEM_READ_CACHE_EN here enables the cache expectations in the reference model.
module tb_mem_sram_ctrl;

    localparam int          AW     = 10;
    localparam int          WAW    = AW - 1;
    localparam int          NWORDS = 1 << WAW;
    localparam logic [31:0] BASE   = 32'd1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdEn [2];
    logic          wrEn [2];
    logic [31:0]   aluRes;
    logic [31:0]   stVal;
    logic [31:0]   rdVal [2];
    logic          rdy [2];
    logic [AW-1:0] sAddr [2];
    logic [15:0]   sDqOut [2];
    logic [15:0]   sDqIn [2];
    logic          sOe [2];
    logic          sWeN [2];
    logic [15:0]   sramMem [2][2*NWORDS];

    int            checks = 0;
    int            failures = 0;

    logic [31:0]   refMem [2][NWORDS];
    bit            known [2][NWORDS];
    logic [31:0]   expRead [2];
    logic [AW-1:0] lastAddr [2];
`ifdef MEM_READ_CACHE_EN
    bit            cValid [2];
    int            cTag [2];
`endif

    always #5 clk = ~clk;

    mem_sram_ctrl #(
        .BASE_ADDR(1024), .SRAM_AW(AW), .WAIT_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(rdEn[0]), .MEM_W_EN(wrEn[0]),
        .ALU_result(aluRes), .ST_val(stVal), .Mem_read_value(rdVal[0]),
        .ready(rdy[0]), .sram_addr(sAddr[0]), .sram_dq_out(sDqOut[0]),
        .sram_dq_oe(sOe[0]), .sram_dq_in(sDqIn[0]), .sram_we_n(sWeN[0])
    );

    mem_sram_ctrl #(
        .BASE_ADDR(1024), .SRAM_AW(AW), .WAIT_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst), .MEM_R_EN(rdEn[1]), .MEM_W_EN(wrEn[1]),
        .ALU_result(aluRes), .ST_val(stVal), .Mem_read_value(rdVal[1]),
        .ready(rdy[1]), .sram_addr(sAddr[1]), .sram_dq_out(sDqOut[1]),
        .sram_dq_oe(sOe[1]), .sram_dq_in(sDqIn[1]), .sram_we_n(sWeN[1])
    );

    // Asynchronous SRAM models: reads are combinational, writes land at the end of each strobe cycle.
    assign sDqIn[0] = sramMem[0][sAddr[0]];
    assign sDqIn[1] = sramMem[1][sAddr[1]];

    always @(posedge clk) begin
        if (!sWeN[0]) sramMem[0][sAddr[0]] <= sDqOut[0];
        if (!sWeN[1]) sramMem[1][sAddr[1]] <= sDqOut[1];
    end

    function automatic int waOf(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return int'((d >> 2) % 32'(NWORDS));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline access on instance s, started just after a rising edge; returns just after the
    // edge that leaves DONE (or the hit cycle) with the enables dropped.
    task automatic applyStimulus(input int s, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d);
        int            w;
        int            wa;
        int            lat;
        bit            isHit;
        bit            gotReady;
        logic [AW-1:0] expAddr;
        w     = (s == 0) ? 1 : 3;
        wa    = waOf(a);
        isHit = 1'b0;
`ifdef MEM_READ_CACHE_EN
        isHit = !wr && cValid[s] && (cTag[s] == wa);
`endif
        lat      = isHit ? 1 : 2 * w + 2;
        aluRes   = a;
        stVal    = d;
        rdEn[s]  = rd;
        wrEn[s]  = wr;
        gotReady = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checkOutput("ready", 32'(rdy[s]), 32'(c == lat));
            if (!isHit && c >= 2 && c <= 2 * w + 1) begin
                expAddr = AW'(2 * wa + ((c > w + 1) ? 1 : 0));
                checkOutput("sram_addr", 32'(sAddr[s]), 32'(expAddr));
                checkOutput("sram_we_n", 32'(sWeN[s]), 32'(!wr));
                checkOutput("sram_dq_oe", 32'(sOe[s]), 32'(wr));
                if (wr) checkOutput("sram_dq_out", 32'(sDqOut[s]),
                                    32'((c > w + 1) ? d[31:16] : d[15:0]));
            end else begin
                checkOutput("quiet we_n", 32'(sWeN[s]), 32'd1);
                checkOutput("quiet dq_oe", 32'(sOe[s]), 32'd0);
            end
            if (isHit) checkOutput("hit sram_addr", 32'(sAddr[s]), 32'(lastAddr[s]));
            if (rdy[s]) begin
                gotReady = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            aluRes = $urandom;
            stVal  = $urandom;
        end
        checkOutput("ready timeout", 32'(gotReady), 32'd1);
        if (wr) begin
            refMem[s][wa] = d;
            known[s][wa]  = 1'b1;
`ifdef MEM_READ_CACHE_EN
            if (cValid[s] && cTag[s] == wa) expRead[s] = d;
`endif
        end else begin
            expRead[s] = refMem[s][wa];
`ifdef MEM_READ_CACHE_EN
            cValid[s] = 1'b1;
            cTag[s]   = wa;
`endif
        end
        if (!isHit) lastAddr[s] = AW'(2 * wa + 1);
        checkOutput("Mem_read_value", rdVal[s], expRead[s]);
        @(posedge clk);
        #1;
        rdEn[s] = 1'b0;
        wrEn[s] = 1'b0;
    endtask

    task automatic modelReset();
        for (int s = 0; s < 2; s++) begin
            expRead[s]  = 32'd0;
            lastAddr[s] = '0;
`ifdef MEM_READ_CACHE_EN
            cValid[s] = 1'b0;
            cTag[s]   = 0;
`endif
        end
    endtask

    initial begin
        int          k;
        int          op;
        logic [31:0] a;
        rst     = 1'b0;
        rdEn[0] = 1'b0; rdEn[1] = 1'b0;
        wrEn[0] = 1'b0; wrEn[1] = 1'b0;
        aluRes  = 32'd0;
        stVal   = 32'd0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NWORDS; i++) begin
                refMem[s][i] = 32'd0;
                known[s][i]  = 1'b0;
            end
        modelReset();

        #2;
        checkOutput("reset ready", 32'(rdy[0]), 32'd1);
        checkOutput("reset Mem_read_value", rdVal[0], 32'd0);
        checkOutput("reset sram_addr", 32'(sAddr[0]), 32'd0);
        checkOutput("reset sram_dq_out", 32'(sDqOut[0]), 32'd0);
        checkOutput("reset sram_dq_oe", 32'(sOe[0]), 32'd0);
        checkOutput("reset sram_we_n", 32'(sWeN[0]), 32'd1);
        checkOutput("reset ready w3", 32'(rdy[1]), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] store/load and cache sequence");
        applyStimulus(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 1'b0, 32'd1028, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'd1028, 32'd0);
        applyStimulus(0, 1'b0, 1'b1, 32'd1028, 32'h00000000);
        applyStimulus(0, 1'b1, 1'b0, 32'd1028, 32'd0);

        $display("[TB] both enables high");
        applyStimulus(0, 1'b1, 1'b1, 32'd1032, 32'h12345678);
        applyStimulus(0, 1'b1, 1'b0, 32'd1032, 32'd0);

        $display("[TB] WAIT_CYCLES=3 instance");
        applyStimulus(1, 1'b0, 1'b1, 32'd1024, 32'hA5A55A5A);
        applyStimulus(1, 1'b1, 1'b0, 32'd1024, 32'd0);

        $display("[TB] reset during high half of a store");
        applyStimulus(0, 1'b0, 1'b1, 32'd1044, 32'hCAFEF00D);
        aluRes  = 32'd1044;
        stVal   = 32'h11112222;
        wrEn[0] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("pre-reset sram_addr", 32'(sAddr[0]), 32'd11);
        checkOutput("pre-reset sram_we_n", 32'(sWeN[0]), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("async reset sram_we_n", 32'(sWeN[0]), 32'd1);
        checkOutput("async reset sram_dq_oe", 32'(sOe[0]), 32'd0);
        checkOutput("async reset sram_addr", 32'(sAddr[0]), 32'd0);
        checkOutput("async reset sram_dq_out", 32'(sDqOut[0]), 32'd0);
        checkOutput("async reset Mem_read_value", rdVal[0], 32'd0);
        checkOutput("reset with req ready", 32'(rdy[0]), 32'd0);
        wrEn[0] = 1'b0;
        #1;
        checkOutput("reset no req ready", 32'(rdy[0]), 32'd1);
        refMem[0][5] = {16'hCAFE, 16'h2222};
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'd1044, 32'd0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 9);
            if (k < 8)       a = BASE + 32'(4 * k);
            else if (k == 8) a = BASE + 32'(4 * (NWORDS + 3));
            else             a = BASE - 32'd4;
            a  = a + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            if (op == 0 && !known[0][waOf(a)]) op = 1;
            applyStimulus(0, op != 1, op != 0, a, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
